// File: rtl/wb_pkg.sv
// Shared encodings for the Wishbone command master: response status codes,
// classic-cycle tag constants and the controller state type.
package wb_pkg;

    localparam logic [1:0] WB_RSP_OK        = 2'b00;
    localparam logic [1:0] WB_RSP_ERR       = 2'b01;
    localparam logic [1:0] WB_RSP_TIMEOUT   = 2'b10;
    localparam logic [1:0] WB_RSP_RETRY_EXH = 2'b11;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_GAP  = 2'd2,
        ST_RESP = 2'd3
    } wb_state_e;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: one bus read/write per command,
// with err/ack/rty handling, bounded retry and a strobe watchdog.
module wb_cmd_master
    import wb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 8,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3,
    parameter int RETRY_GAP = 4
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic [1:0]      rsp_status,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic [2:0]      wb_cti_o,
    output logic [1:0]      wb_bte_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_rty_i
);

    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST  = 16'(RETRY_GAP - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

    wb_state_e     state;
    logic          cyc_q;
    logic          we_q;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] dat_q;
    logic [15:0]   tmo_cnt;
    logic [7:0]    rty_cnt;

    assign cmd_ready = (state == ST_IDLE) && !wb_rst;
    assign rsp_valid = (state == ST_RESP);

    // Bus outputs are gated by the registered cycle flag so they read zero between transfers.
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = cyc_q & we_q;
    assign wb_adr_o = cyc_q ? adr_q : '0;
    assign wb_dat_o = cyc_q ? dat_q : '0;
    assign wb_sel_o = {(DW/8){cyc_q}};
    assign wb_cti_o = CTI_CLASSIC;
    assign wb_bte_o = BTE_LINEAR;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state      <= ST_IDLE;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            tmo_cnt    <= '0;
            rty_cnt    <= '0;
            rsp_dat    <= '0;
            rsp_status <= WB_RSP_OK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        we_q    <= cmd_we;
                        adr_q   <= cmd_adr;
                        dat_q   <= cmd_dat;
                        tmo_cnt <= '0;
                        rty_cnt <= '0;
                        cyc_q   <= 1'b1;
                        state   <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // Any exit drops cyc on the sampling edge so a held ack cannot retire twice.
                    if (wb_err_i) begin
                        rsp_status <= WB_RSP_ERR;
                        rsp_dat    <= '0;
                        cyc_q      <= 1'b0;
                        state      <= ST_RESP;
                    end else if (wb_ack_i) begin
                        rsp_status <= WB_RSP_OK;
                        rsp_dat    <= we_q ? '0 : wb_dat_i;
                        cyc_q      <= 1'b0;
                        state      <= ST_RESP;
                    end else if (wb_rty_i) begin
                        cyc_q <= 1'b0;
                        if (rty_cnt < RETRY_MAX) begin
                            rty_cnt <= rty_cnt + 8'd1;
                            tmo_cnt <= '0;
                            state   <= ST_GAP;
                        end else begin
                            rsp_status <= WB_RSP_RETRY_EXH;
                            rsp_dat    <= '0;
                            state      <= ST_RESP;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        rsp_status <= WB_RSP_TIMEOUT;
                        rsp_dat    <= '0;
                        cyc_q      <= 1'b0;
                        state      <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    // The watchdog counter doubles as the idle-gap counter while off the bus.
                    if (tmo_cnt == GAP_LAST) begin
                        tmo_cnt <= '0;
                        cyc_q   <= 1'b1;
                        state   <= ST_BUS;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_dat    <= '0;
                        rsp_status <= WB_RSP_OK;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone classic single-transfer initiator for the DE2-115 SoC. It turns a simple valid/ready command stream into one Wishbone read or write per command, and returns a response with data and status. It is the master-side counterpart of the board's simple slaves (LED, switch, GPIO), and is used by debug and bring-up logic to drive those peripherals without the CPU. It handles ack, err and rty terminations, bounded retry and a bus-timeout watchdog.

## Interface
Parameters:
- AW, 32: address width.
- DW, 8: data width. Must be a multiple of 8.
- TIMEOUT, 255: maximum cycles stb may stay high without a termination. Range 1..65535.
- MAX_RETRY, 3: number of re-issues allowed after rty. 0 means no retry.
- RETRY_GAP, 4: idle cycles between an rty and the re-issue. Minimum 1.

Ports:
- wb_clk  in  1  clock. Single clock domain.
- wb_rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  AW  target address.
- cmd_dat  in  DW  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_dat  out  DW  read data. 0 for writes.
- rsp_status  out  2  00 OK, 01 ERR, 10 TIMEOUT, 11 RETRY_EXHAUSTED.
- wb_adr_o  out  AW  Wishbone address.
- wb_dat_o  out  DW  Wishbone write data.
- wb_sel_o  out  DW/8  byte selects. All ones during a cycle.
- wb_we_o  out  1  Wishbone write enable.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_cti_o  out  3  constant 3'b000 (classic).
- wb_bte_o  out  2  constant 2'b00.
- wb_dat_i  in  DW  read data from slave.
- wb_ack_i  in  1  slave ack.
- wb_err_i  in  1  slave error.
- wb_rty_i  in  1  slave retry request.

## Operation
- States: IDLE, BUS, GAP, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch we/adr/dat, clear the retry and timeout counters, go to BUS.
- BUS:
  - cyc_o = stb_o = 1. adr/dat/we/sel come from the latched command.
  - The timeout counter increments every cycle.
  - Terminations sampled each edge, priority err > ack > rty:
    - err: status 01, go to RESP.
    - ack: status 00; on a read, rsp_dat <= wb_dat_i. Go to RESP.
    - rty: if retry count < MAX_RETRY, increment it and go to GAP; otherwise status 11, go to RESP.
    - No termination and counter reaches TIMEOUT: status 10, go to RESP.
  - If a termination and the timeout terminal count occur on the same cycle, the termination wins.
- GAP:
  - cyc_o = stb_o = 0.
  - Wait RETRY_GAP cycles, clear the timeout counter, return to BUS with the same command.
- RESP:
  - rsp_valid = 1; outputs held stable until rsp_valid & rsp_ready, then go to IDLE.
  - No new command is accepted while a response is pending.
- cyc_o and stb_o are registered and always equal. They deassert on the same edge that samples the termination, so a one-cycle ack from the slave cannot retire a second transfer.
- rsp_dat = 0 for writes and for any non-OK status.
- wb_dat_o, wb_adr_o and wb_we_o are driven to 0 when cyc_o = 0.

## Timing
- Reset values: cmd_ready 0 while in reset, then 1 in IDLE. All other outputs 0 (rsp_valid, rsp_dat, rsp_status, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o).
- Latency against a slave that acks one cycle after stb (the LED slave): command accepted at edge 0, stb high in cycle 1, ack sampled at edge 2, rsp_valid high in cycle 3.
- Back-to-back throughput: one transfer per 4 cycles with rsp_ready held at 1. cmd_ready returns the cycle after the response handshake.
- Timeout: a dead bus gives status 10 exactly TIMEOUT cycles after stb first rises.
- Reset mid-transfer: cyc/stb drop asynchronously, the command is discarded and no response is produced.

## Structure
- Package wb_pkg:
  - status encodings (WB_RSP_OK/ERR/TIMEOUT/RETRY_EXH);
  - CTI_CLASSIC = 3'b000 and BTE_LINEAR = 2'b00;
  - the state enum.
- Single module, no sub-module. The timeout counter is 16 bits and the retry counter is 8 bits, both inline.

## Test plan
- Write 0x5A to the LED slave at 0x9100_0000:
  - wb_dat_o = 0x5A at cycle 1, LED output = 0x5A at cycle 3.
  - rsp_valid in cycle 3 with status 00 and rsp_dat 0x00.
- Read from a slave returning 0xC3:
  - rsp_dat = 0xC3, status 00.
  - cyc_o high for exactly 2 cycles.
- Slave asserts rty twice then ack, MAX_RETRY = 3, RETRY_GAP = 4:
  - three stb phases separated by 4-cycle gaps, final status 00.
  - With 4 consecutive rty responses: status 11 after the 4th.
- No slave response, TIMEOUT = 10: status 10 with rsp_valid 11 cycles after command acceptance; cyc drops on the same edge.
- err and ack asserted together: status 01, rsp_dat 0.
- rsp_ready held low for 20 cycles:
  - cmd_ready stays 0 and the response is stable throughout;
  - wb_rst pulsed mid-BUS clears cyc/stb immediately and returns the block to IDLE with no response.
